// File: rtl/gates_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// gates_sweep_ctrl
//   Self-test sequencer for the 2-input / 3-output combinational Gates unit.
//   A start request walks gate_in through vectors 0..3. Each vector is held for
//   SETTLE cycles, then the unit's response is captured into a result table and
//   compared with the EXPECTED truth table. At the end it reports pass/fail,
//   the first failing vector and a running sweep count.
//
// Parameters
//   SETTLE    cycles each vector is held before capture (1..15)
//   EXPECTED  expected table, entry i at bits [3i+2:3i]
//             (bit0=AND, bit1=OR, bit2=XOR)
//
// Ports
//   CLK          in   system clock, rising edge
//   Reset        in   synchronous active-high reset
//   start        in   sweep request, level sampled, accepted only in IDLE
//   gate_in      out  vector driven to the Gates unit
//   gate_out     in   Gates unit response
//   busy         out  sweep in progress
//   done         out  one-cycle completion pulse
//   results      out  captured table, EXPECTED packing
//   mismatch     out  bit i set when entry i differs from EXPECTED
//   pass         out  set at completion when no entry mismatched
//   first_fail   out  lowest mismatching vector, 0 on pass
//   sweep_count  out  completed sweeps, wraps modulo 256
//   dbg_state    out  current FSM state (0=IDLE, 1=SETTLE, 2=DONE)
//
// Handshake: start is a level request with no ready signal; it is consumed
// at an edge where the controller is IDLE and ignored in every other state.
// -----------------------------------------------------------------------------
module gates_sweep_ctrl #(
  parameter int unsigned SETTLE   = 2,
  parameter logic [11:0] EXPECTED = 12'h7B0
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        start,
  output logic [1:0]  gate_in,
  input  logic [2:0]  gate_out,
  output logic        busy,
  output logic        done,
  output logic [11:0] results,
  output logic [3:0]  mismatch,
  output logic        pass,
  output logic [1:0]  first_fail,
  output logic [7:0]  sweep_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_e      state_q, state_d;
  logic [1:0]  vec_q, vec_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        capture;

  logic [1:0]  gate_in_q, gate_in_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [11:0] results_q, results_d;
  logic [3:0]  mismatch_q, mismatch_d;
  logic        pass_q, pass_d;
  logic [1:0]  first_fail_q, first_fail_d;
  logic [7:0]  sweep_count_q, sweep_count_d;
  logic [2:0]  exp_entry;

  // State register and all output/counter flops.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      vec_q         <= 2'd0;
      cnt_q         <= 4'd0;
      gate_in_q     <= 2'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      results_q     <= 12'd0;
      mismatch_q    <= 4'd0;
      pass_q        <= 1'b0;
      first_fail_q  <= 2'd0;
      sweep_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      vec_q         <= vec_d;
      cnt_q         <= cnt_d;
      gate_in_q     <= gate_in_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      results_q     <= results_d;
      mismatch_q    <= mismatch_d;
      pass_q        <= pass_d;
      first_fail_q  <= first_fail_d;
      sweep_count_q <= sweep_count_d;
    end
  end

  // Next-state logic, including the vector/settle counters.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETTLE;
          vec_d   = 2'd0;
          cnt_d   = 4'd0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          capture = 1'b1;
          cnt_d   = 4'd0;
          if (vec_q == 2'd3) begin
            state_d = ST_DONE;
            vec_d   = 2'd0;
          end else begin
            vec_d = vec_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic. Outputs are computed from the next state so that every
  // port comes straight from a flop and lines up with the state it reflects.
  always_comb begin
    gate_in_d     = (state_d == ST_SETTLE) ? vec_d : 2'd0;
    busy_d        = (state_d == ST_SETTLE);
    done_d        = (state_d == ST_DONE);
    results_d     = results_q;
    mismatch_d    = mismatch_q;
    pass_d        = pass_q;
    first_fail_d  = first_fail_q;
    sweep_count_d = sweep_count_q;
    exp_entry     = EXPECTED[3*vec_q +: 3];

    // A newly accepted sweep starts from a clean report; the count persists.
    if (state_q == ST_IDLE && state_d == ST_SETTLE) begin
      results_d    = 12'd0;
      mismatch_d   = 4'd0;
      pass_d       = 1'b0;
      first_fail_d = 2'd0;
    end

    if (capture) begin
      results_d[3*vec_q +: 3] = gate_out;
      mismatch_d[vec_q]       = (gate_out != exp_entry);
    end

    // Summary uses mismatch_d so the vector-3 result captured on this same
    // edge is included.
    if (state_q == ST_SETTLE && state_d == ST_DONE) begin
      pass_d       = (mismatch_d == 4'd0);
      first_fail_d = 2'd0;
      for (int i = 3; i >= 0; i--) begin
        if (mismatch_d[i]) first_fail_d = 2'(i);
      end
      sweep_count_d = sweep_count_q + 8'd1;
    end
  end

  assign gate_in     = gate_in_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign results     = results_q;
  assign mismatch    = mismatch_q;
  assign pass        = pass_q;
  assign first_fail  = first_fail_q;
  assign sweep_count = sweep_count_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/gates_sweep_ctrl.md
Name: gates_sweep_ctrl

Overview:
- Self-test sequencer for the 2-input / 3-output combinational Gates unit.
- On a start request it drives every input vector 0..3 into the unit and holds each vector for a programmable settle time.
- It captures each 3-bit response into a result table and compares it against an expected truth table.
- It reports pass/fail, the first failing vector and a completed-sweep count; it sits between lab control logic and the Gates datapath.

Parameters:
- SETTLE, 2: cycles each vector is held before capture; legal range 1..15 (4-bit counter).
- EXPECTED, 12'h7B0: expected table. Entry i at bits [3i+2:3i] is the response to gate_in=i. Per entry, bit0=AND, bit1=OR, bit2=XOR.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  sweep request; level sampled, accepted only in IDLE.
- gate_in  out  2  vector driven to the Gates unit input.
- gate_out  in  3  Gates unit response.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- results  out  12  captured table, same packing as EXPECTED.
- mismatch  out  4  bit i set if entry i != EXPECTED entry i.
- pass  out  1  set at completion if mismatch==0.
- first_fail  out  2  lowest i with mismatch[i]=1; 0 when pass=1.
- sweep_count  out  8  completed sweeps, wraps 255->0.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high; Reset=1 at an edge forces IDLE and clears all outputs and internal counters to 0, including gate_in, busy, done, results, mismatch, pass, first_fail and sweep_count.
- Reset mid-sweep: aborts immediately, no done pulse.
- Reset has priority over start.
- All outputs are registered; there is no combinational path from gate_out or start to any output.
- States: IDLE, SETTLE, DONE.
- IDLE: busy=0, done=0, gate_in=0. If start=1 at an edge, then:
  - next state SETTLE, vec=0, cnt=0, busy=1;
  - results, mismatch, pass and first_fail are cleared;
  - sweep_count is kept.
- SETTLE:
  - gate_in=vec; cnt increments each edge.
  - At the edge where cnt==SETTLE-1: results[vec] <= gate_out and mismatch[vec] <= (gate_out != EXPECTED[vec]).
  - Then, if vec==3, go to DONE; otherwise vec+1 and cnt=0.
  - Vector transitions are back to back with no gap cycles.
- DONE (exactly 1 cycle):
  - done=1, busy=0, gate_in=0.
  - pass, first_fail and sweep_count+1 are registered on entry, using the final mismatch including vec 3.
  - Next state is IDLE unconditionally.
  - start is ignored in DONE and SETTLE; there is no queuing.
- Latency, with start accepted at edge t0:
  - busy is high from t0 to t0+4*SETTLE.
  - done is high from t0+4*SETTLE to t0+4*SETTLE+1.
  - With start held high continuously, the sweep period is 4*SETTLE+2 cycles.
- Outputs hold their values in IDLE until the next accepted start or Reset.
- sweep_count wraps modulo 256 with no saturation.

Test Plan:
- Reset check: Reset=1 for 2 cycles with start=1 -> all outputs 0, no sweep starts while Reset=1.
- Golden sweep (correct Gates model, SETTLE=2): single-cycle start pulse -> gate_in sequence 0,0,1,1,2,2,3,3; done one cycle later; results=12'h7B0, mismatch=4'b0000, pass=1, first_fail=0, sweep_count=1.
- Faulty unit (XOR output stuck at 0), SETTLE=2 -> results=12'h690, mismatch=4'b0110, pass=0, first_fail=1, done on the same cycle as the golden case.
- start held high for 30 cycles, SETTLE=2 -> a done pulse every 10 cycles; sweep_count=1,2,3; start during busy/done has no effect.
- Reset asserted 3 cycles into a sweep -> everything cleared, gate_in=0, no done. A new start then completes normally with results=12'h7B0 and sweep_count=1.
- SETTLE=1 instance, start pulse -> gate_in 0,1,2,3 on consecutive cycles; done 4 cycles after acceptance. Preload 255 sweeps -> sweep_count wraps to 0.
